// File: rtl/mul_seq_unit.sv
//------------------------------------------------------------------------------
// mul_seq_unit
//
// Iterative shift-add multiplier for the `mul` opcode of the multicycle
// datapath. The control FSM pulses Start from its EX state with the register
// file operands. It holds in EX until Done, then writes ResultLo back through
// the ALUOut path.
//
// Signed operands are converted to magnitudes on capture. The sign of the
// product is kept in a flag and applied once, when the result is loaded.
// The multiplier consumes one bit of the multiplier operand per RUN cycle,
// LSB first.
//
// Optional feature macro: MUL_EARLY_EXIT_EN
//   When defined, RUN ends as soon as the remaining multiplier bits are all
//   zero. The accumulator is then aligned by the outstanding shift count in a
//   single step. The result is identical to the full-length run; only the
//   latency shrinks.
//   When undefined, RUN always lasts WIDTH cycles and no alignment shifter is
//   built.
//
// Parameters:
//   WIDTH     operand width; the product is 2*WIDTH bits
//   CNT_W     iteration counter width, 2**CNT_W must exceed WIDTH
//
// Ports:
//   CLK       in   system clock, rising edge
//   CLR       in   asynchronous active-low reset
//   Start     in   request pulse, honoured only in IDLE or DONE
//   SignedOp  in   1 = two's complement operands, 0 = unsigned
//   SrcA      in   multiplicand (WIDTH)
//   SrcB      in   multiplier   (WIDTH)
//   Busy      out  high while iterating (RUN)
//   Done      out  one-cycle pulse, result valid
//   ResultLo  out  low half of the product (WIDTH)
//   ResultHi  out  high half of the product (WIDTH)
//------------------------------------------------------------------------------
module mul_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             Start,
    input  logic             SignedOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Magnitude of a possibly-signed operand. The most negative value maps
    // onto 2**(WIDTH-1), which still fits the unsigned WIDTH-bit field.
    function automatic logic [WIDTH-1:0] f_magnitude(
        input logic [WIDTH-1:0] v,
        input logic             is_signed
    );
        if (is_signed && v[WIDTH-1])
            return ~v + WIDTH'(1);
        else
            return v;
    endfunction

    // Two's-complement negation of the full product, modulo 2**(2*WIDTH).
    function automatic logic [2*WIDTH-1:0] f_negate_prod(
        input logic [2*WIDTH-1:0] v
    );
        return ~v + (2*WIDTH)'(1);
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_load;

    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [WIDTH-1:0]     r_res_lo;
    logic [WIDTH-1:0]     r_res_hi;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_step;
    logic [2*WIDTH-1:0]   w_acc_fin;
    logic [WIDTH-1:0]     w_mplier_step;
    logic                 w_last_iter;
    logic                 w_early;
    logic                 w_run_done;
    logic [2*WIDTH-1:0]   w_result;

    // One shift-add step: add the multiplicand into the upper half, keeping
    // the carry. Then shift {carry, accumulator} right by one.
    assign w_sum         = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                         + {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_acc_step    = (2*WIDTH)'({w_sum, r_acc[WIDTH-1:0]} >> 1);
    assign w_mplier_step = r_mplier >> 1;
    assign w_last_iter   = (r_cnt == CNT_W'(1));

`ifdef MUL_EARLY_EXIT_EN
    // Once no set multiplier bits remain, the remaining iterations would only
    // shift. Apply all of them at once. The carry into the top is zero from
    // here on, so a logical right shift is exact.
    assign w_early   = (w_mplier_step == {WIDTH{1'b0}});
    assign w_acc_fin = w_acc_step >> (r_cnt - CNT_W'(1));
`else
    assign w_early   = 1'b0;
    assign w_acc_fin = w_acc_step;
`endif

    assign w_run_done = w_last_iter || w_early;
    assign w_result   = r_neg ? f_negate_prod(w_acc_fin) : w_acc_fin;

    // State register
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic. Start is only honoured in IDLE and DONE, so a
    // request arriving during RUN is dropped rather than queued.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_run_done)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (Start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers. The whole unit is cleared on reset, so an
    // interrupted operation leaves nothing behind.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else if (w_load) begin
            r_mcand  <= f_magnitude(SrcA, SignedOp);
            r_mplier <= f_magnitude(SrcB, SignedOp);
            r_neg    <= SignedOp & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= CNT_W'(WIDTH);
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_fin;
            r_mplier <= w_mplier_step;
            r_cnt    <= r_cnt - CNT_W'(1);
            // Results only move on DONE entry. They hold through Start and RUN.
            if (w_run_done) begin
                r_res_hi <= w_result[2*WIDTH-1:WIDTH];
                r_res_lo <= w_result[WIDTH-1:0];
            end
        end
    end

    assign Busy     = (r_state == S_RUN);
    assign Done     = (r_state == S_DONE);
    assign ResultLo = r_res_lo;
    assign ResultHi = r_res_hi;

endmodule

// File: tb/tb_mul_seq_unit.sv
module tb_mul_seq_unit;

    localparam int W = 32;
`ifdef MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         CLR;
    logic         Start;
    logic         SignedOp;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         Busy;
    logic         Done;
    logic [W-1:0] ResultLo;
    logic [W-1:0] ResultHi;

    int n_cmp  = 0;
    int n_fail = 0;

    int           dcyc;
    int           dcnt;
    int           bcnt;
    logic [W-1:0] lo0;
    int           d1;
    int           d2;

    mul_seq_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .Start    (Start),
        .SignedOp (SignedOp),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .Busy     (Busy),
        .Done     (Done),
        .ResultLo (ResultLo),
        .ResultHi (ResultHi)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Launches one operation and watches 45 cycles.
    // Cycle 1 is the cycle right after the Start edge.
    // poke > 0 raises Start with operands 2 x 2 during that cycle only.
    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke, output int done_cyc, output int done_cnt,
                          output int busy_cnt, output logic [W-1:0] lo_start);
        done_cyc = 0;
        done_cnt = 0;
        busy_cnt = 0;
        lo_start = '0;
        SignedOp = sgn;
        SrcA     = a;
        SrcB     = b;
        Start    = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) begin
                Start    = 1'b0;
                lo_start = ResultLo;
            end
            if (poke > 0 && cyc == poke) begin
                Start    = 1'b1;
                SignedOp = 1'b0;
                SrcA     = 32'd2;
                SrcB     = 32'd2;
            end
            if (poke > 0 && cyc == poke + 1)
                Start = 1'b0;
            if (Busy)
                busy_cnt++;
            if (Done) begin
                done_cnt++;
                if (done_cyc == 0)
                    done_cyc = cyc;
            end
        end
    endtask

    initial begin
        CLR      = 1'b1;
        Start    = 1'b0;
        SignedOp = 1'b0;
        SrcA     = '0;
        SrcB     = '0;
        #2 CLR = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_busy", 64'(Busy), 64'(0));
        check("rst_done", 64'(Done), 64'(0));
        check("rst_lo", 64'(ResultLo), 64'(0));
        check("rst_hi", 64'(ResultHi), 64'(0));
        CLR = 1'b1;
        @(negedge CLK);

        // unsigned 7 x 6
        run_op(1'b0, 32'd7, 32'd6, 0, dcyc, dcnt, bcnt, lo0);
        check("u7x6_done_cyc", 64'(dcyc), EE ? 64'(4) : 64'(33));
        check("u7x6_busy_cnt", 64'(bcnt), EE ? 64'(3) : 64'(32));
        check("u7x6_done_cnt", 64'(dcnt), 64'(1));
        check("u7x6_lo", 64'(ResultLo), 64'd42);
        check("u7x6_hi", 64'(ResultHi), 64'd0);

        // unsigned all-ones squared; previous result must hold across Start
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, dcyc, dcnt, bcnt, lo0);
        check("hold_at_start", 64'(lo0), 64'd42);
        check("uff_done_cyc", 64'(dcyc), 64'(33));
        check("uff_hi", 64'(ResultHi), 64'h0000_0000_FFFF_FFFE);
        check("uff_lo", 64'(ResultLo), 64'h0000_0000_0000_0001);

        // signed -3 x 5
        run_op(1'b1, 32'hFFFF_FFFD, 32'd5, 0, dcyc, dcnt, bcnt, lo0);
        check("sm3x5_done_cyc", 64'(dcyc), EE ? 64'(4) : 64'(33));
        check("sm3x5_hi", 64'(ResultHi), 64'h0000_0000_FFFF_FFFF);
        check("sm3x5_lo", 64'(ResultLo), 64'h0000_0000_FFFF_FFF1);

        // signed 6 x -7
        run_op(1'b1, 32'd6, 32'hFFFF_FFF9, 0, dcyc, dcnt, bcnt, lo0);
        check("s6xm7_hi", 64'(ResultHi), 64'h0000_0000_FFFF_FFFF);
        check("s6xm7_lo", 64'(ResultLo), 64'h0000_0000_FFFF_FFD6);

        // signed most-negative squared
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 0, dcyc, dcnt, bcnt, lo0);
        check("smin_done_cyc", 64'(dcyc), 64'(33));
        check("smin_hi", 64'(ResultHi), 64'h0000_0000_4000_0000);
        check("smin_lo", 64'(ResultLo), 64'd0);

        // Start mid-RUN with 2 x 2 is ignored
        run_op(1'b0, 32'd100, 32'd3, 1, dcyc, dcnt, bcnt, lo0);
        check("midrun_done_cnt", 64'(dcnt), 64'(1));
        check("midrun_done_cyc", 64'(dcyc), EE ? 64'(3) : 64'(33));
        check("midrun_lo", 64'(ResultLo), 64'd300);
        check("midrun_hi", 64'(ResultHi), 64'd0);

        // early-exit style operands
        run_op(1'b0, 32'd9, 32'd0, 0, dcyc, dcnt, bcnt, lo0);
        check("u9x0_done_cyc", 64'(dcyc), EE ? 64'(2) : 64'(33));
        check("u9x0_lo", 64'(ResultLo), 64'd0);
        check("u9x0_hi", 64'(ResultHi), 64'd0);
        run_op(1'b0, 32'd9, 32'd5, 0, dcyc, dcnt, bcnt, lo0);
        check("u9x5_done_cyc", 64'(dcyc), EE ? 64'(4) : 64'(33));
        check("u9x5_lo", 64'(ResultLo), 64'd45);

        // back-to-back: Start during the Done cycle
        SignedOp = 1'b0;
        SrcA     = 32'd5;
        SrcB     = 32'd7;
        Start    = 1'b1;
        d1 = 0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge CLK);
            if (cyc == 1)
                Start = 1'b0;
            if (Done) begin
                d1 = cyc;
                break;
            end
        end
        check("b2b_first_cyc", 64'(d1), EE ? 64'(4) : 64'(33));
        check("b2b_first_lo", 64'(ResultLo), 64'd35);
        SrcA  = 32'd11;
        SrcB  = 32'd13;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        check("b2b_busy_no_idle", 64'(Busy), 64'(1));
        check("b2b_done_single", 64'(Done), 64'(0));
        d2 = 0;
        for (int cyc = 2; cyc <= 45; cyc++) begin
            @(negedge CLK);
            if (Done) begin
                d2 = cyc;
                break;
            end
        end
        check("b2b_second_cyc", 64'(d2), EE ? 64'(5) : 64'(33));
        check("b2b_second_lo", 64'(ResultLo), 64'd143);
        @(negedge CLK);
        check("b2b_done_drops", 64'(Done), 64'(0));

        // reset in the middle of RUN
        SrcA  = 32'd3;
        SrcB  = 32'hFFFF_FFFF;
        Start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge CLK);
            if (cyc == 1)
                Start = 1'b0;
        end
        check("mid_rst_pre_busy", 64'(Busy), 64'(1));
        CLR = 1'b0;
        #1;
        check("mid_rst_busy", 64'(Busy), 64'(0));
        check("mid_rst_done", 64'(Done), 64'(0));
        check("mid_rst_lo", 64'(ResultLo), 64'(0));
        check("mid_rst_hi", 64'(ResultHi), 64'(0));
        @(negedge CLK);
        CLR  = 1'b1;
        dcnt = 0;
        bcnt = 0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge CLK);
            if (Done)
                dcnt++;
            if (Busy)
                bcnt++;
        end
        check("post_rst_no_done", 64'(dcnt), 64'(0));
        check("post_rst_no_busy", 64'(bcnt), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq_unit.md
Name: mul_seq_unit

Overview:
- Iterative shift-add multiplier executing the `mul` opcode in the multicycle datapath, downstream of the control FSM.
- The FSM's EX state pulses Start with SrcA/SrcB from the register-file output latches.
- The FSM holds in EX until Done, then writes ResultLo back through the ALUOut path in WB.
- Supports signed (two's complement) and unsigned operands; full 2*WIDTH product exposed.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK  input  1  system clock, rising-edge active
CLR  input  1  reset, asynchronous, active-low
Start  input  1  request pulse; sampled only in IDLE or DONE
SignedOp  input  1  1 = signed multiply, 0 = unsigned; sampled with Start
SrcA  input  WIDTH  multiplicand; sampled with Start
SrcB  input  WIDTH  multiplier; sampled with Start
Busy  output  1  high while an operation is in progress (RUN state)
Done  output  1  single-cycle pulse, result valid
ResultLo  output  WIDTH  low half of product
ResultHi  output  WIDTH  high half of product

Behaviour:
- Reset (CLR low, any time, including mid-operation): state=IDLE; Busy=0, Done=0, ResultLo=0, ResultHi=0; counter, accumulator and operand registers cleared. Any in-flight operation is discarded; no Done is produced for it.
- States: IDLE, RUN, DONE (2-bit encoding; the unused code returns to IDLE).
- IDLE: Start=1 at an edge captures the operands and moves to RUN. Start=0 stays in IDLE.
- Operand capture:
  - Signed: store |SrcA| and |SrcB| as WIDTH-bit unsigned magnitudes; NegFlag = SrcA[MSB] XOR SrcB[MSB]. The magnitude of the most-negative value is 2^(WIDTH-1), representable unsigned.
  - Unsigned: store the raw operands; NegFlag=0.
  - Accumulator (2*WIDTH) cleared; counter loaded with WIDTH.
- RUN: one multiplier bit per cycle, LSB first.
  - If the current multiplier LSB=1, add the multiplicand to the accumulator upper half with carry.
  - Shift the {carry, accumulator} and multiplier right by 1; decrement the counter.
  - When the counter reaches 1 on this edge, go to DONE.
- Entering DONE: load {ResultHi, ResultLo} with the accumulator, or its 2*WIDTH two's-complement negation if NegFlag=1.
- DONE: Done=1 for exactly one cycle.
  - Start=1 in DONE begins a new operation (back-to-back) and goes to RUN.
  - Otherwise go to IDLE.
- Latency: the edge that samples Start is edge 0. RUN spans edges 1..WIDTH. Done is high in the cycle following edge WIDTH, i.e. WIDTH+1 cycles after the Start edge.
- Busy=1 exactly while in RUN; Busy=0 in the DONE cycle.
- Start while in RUN is ignored; it is neither queued nor able to corrupt operands.
- ResultLo/ResultHi hold their value until the next DONE entry or reset. They do not change at Start or during RUN.
- Arithmetic is modulo 2^(2*WIDTH). Overflow is impossible for the full product.

Optional Feature:
Macro MUL_EARLY_EXIT_EN.
- Defined: in RUN, if the remaining (shifted) multiplier is all zero, the accumulator is aligned by the remaining shift count in one cycle and the unit goes to DONE on that edge.
  - Latency becomes (index of highest set bit of |SrcB|)+1 RUN cycles, minimum 1 (SrcB=0 gives exactly 1 RUN cycle).
  - Result is bit-identical to the non-early-exit case.
- Not defined: RUN always lasts exactly WIDTH cycles regardless of operands. The shift-alignment logic is not synthesized.

Test Plan:
- Reset, then unsigned 7 x 6 (WIDTH=32) -> Busy high for 32 cycles; Done pulses once 33 cycles after the Start edge; ResultHi=0, ResultLo=42; both outputs hold afterwards.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> ResultHi=0xFFFFFFFE, ResultLo=0x00000001.
- Signed -3 x 5 -> ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFF1. Signed 0x80000000 x 0x80000000 -> ResultHi=0x40000000, ResultLo=0.
- Start pulse mid-RUN with new operands 2 x 2 -> ignored; the original result is delivered. Start asserted during the Done cycle -> new RUN begins with no IDLE cycle, and the second Done arrives 33 cycles later.
- CLR low at RUN cycle 10 -> all outputs 0 immediately; after release, no Done occurs without a new Start.
- With MUL_EARLY_EXIT_EN: 9 x 0 -> Done 2 cycles after Start, result 0. 9 x 5 -> Done 4 cycles after Start, ResultLo=45. Without the macro, both cases take 33 cycles.
